// File: rtl/fifo8x8_pkg.sv
// Shared sizing for the fifo8x8 slice: legacy `FIFO_* macros plus typed localparams.
// Optional error flags are enabled in the top with FIFO8X8_ERR_EN.
`ifndef FIFO_DEFS_V
`define FIFO_DEFS_V
`define FIFO_WIDTH 8
`define FIFO_DEPTH 8
`define FIFO_PTR_W 3
`define FIFO_CNT_W 4
`define FIFO_FULL_CNT 4'd8
`endif

package fifo8x8_pkg;
  localparam int WIDTH = `FIFO_WIDTH;
  localparam int DEPTH = `FIFO_DEPTH;
  localparam int PTR_W = `FIFO_PTR_W;
  localparam int CNT_W = `FIFO_CNT_W;
  localparam logic [CNT_W-1:0] FULL_CNT = `FIFO_FULL_CNT;
  localparam logic [CNT_W-1:0] EMPTY_CNT = 4'd0;
endpackage

// File: rtl/Mux8way8bit.sv
// 8-way, 8-bit combinational selector used for the FIFO read path.
module Mux8way8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  input  logic [7:0] e,
  input  logic [7:0] f,
  input  logic [7:0] g,
  input  logic [7:0] h,
  input  logic [2:0] sel,
  output logic [7:0] out
);

  // Select one of eight bytes.
  always_comb begin
    out = 8'h00;
    case (sel)
      3'd0:    out = a;
      3'd1:    out = b;
      3'd2:    out = c;
      3'd3:    out = d;
      3'd4:    out = e;
      3'd5:    out = f;
      3'd6:    out = g;
      3'd7:    out = h;
      default: out = 8'h00;
    endcase
  end

endmodule

// File: rtl/ptr_counter3.sv
// 3-bit wrapping pointer counter with enable and synchronous active-high reset.
module ptr_counter3
  import fifo8x8_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [PTR_W-1:0] q
);

  // Advance on enable; 7 rolls over to 0 through the natural 3-bit wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 3'd0;
    end else if (en) begin
      q <= q + 3'd1;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/fifo8x8.sv
// 8x8 show-ahead synchronous FIFO; head byte is muxed out by the read pointer.
// Define FIFO8X8_ERR_EN to add sticky overflow/underflow outputs.
module fifo8x8
  import fifo8x8_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inData,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] outData,
  output logic             full,
  output logic             empty,
`ifdef FIFO8X8_ERR_EN
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Acceptance uses the pre-edge flags, so a full FIFO still takes a pop and an empty one a push.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == EMPTY_CNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  ptr_counter3 u_wr_ptr (.clk(clk), .reset(reset), .en(push_ok), .q(wr_ptr));
  ptr_counter3 u_rd_ptr (.clk(clk), .reset(reset), .en(pop_ok),  .q(rd_ptr));

  // Storage write; popped entries are left in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= inData;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  // Occupancy tracks accepted operations; equal pointers are disambiguated by this alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  Mux8way8bit u_head_mux (
    .a(mem[0]), .b(mem[1]), .c(mem[2]), .d(mem[3]),
    .e(mem[4]), .f(mem[5]), .g(mem[6]), .h(mem[7]),
    .sel(rd_ptr),
    .out(outData)
  );

`ifdef FIFO8X8_ERR_EN
  // Sticky error flags: raw request against the pre-edge flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (push & full);
      underflow <= underflow | (pop & empty);
    end
  end
`endif

endmodule
